// File: rtl/seg_write_arbiter.sv
// Round-robin bus master that lets three requesters update the seven-segment display (value write, then dot write).
// Build option SEG_ARB_HOLD_EN adds a HOLD state that keeps the block idle for HOLD_CYCLES cycles after each update.
module seg_write_arbiter #(
  parameter logic [7:0]  SEG_BASE_ADDR = 8'hD0,
  parameter int unsigned HOLD_CYCLES   = 50000,
  parameter int unsigned HOLD_WIDTH    = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] REQ,
  input  logic [7:0] VALUE0,
  input  logic [7:0] VALUE1,
  input  logic [7:0] VALUE2,
  input  logic [3:0] DOTS0,
  input  logic [3:0] DOTS1,
  input  logic [3:0] DOTS2,
  output logic [2:0] ACK,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output wire  [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  output wire        BUS_WE,
  output logic       BUSY
);

  if (64'(HOLD_CYCLES) >= (64'd1 << HOLD_WIDTH)) begin : g_hold_range
    $error("HOLD_CYCLES does not fit in HOLD_WIDTH bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_WR_VAL,
    S_WR_DOT,
    S_DONE
`ifdef SEG_ARB_HOLD_EN
    , S_HOLD
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_last;
  logic [1:0] r_win;
  logic [7:0] r_value;
  logic [3:0] r_dots;
  logic [1:0] w_pick;
  logic       w_drive;
  logic       w_own_idle;
  logic       w_hold_done;

  // Candidate order is last+1, last+2, last; REQ is only looked at when nonzero.
  always_comb begin
    w_pick = 2'd0;
    case (r_last)
      2'd0:    w_pick = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
      2'd1:    w_pick = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
      default: w_pick = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
    endcase
  end

`ifdef SEG_ARB_HOLD_EN
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
  logic [HOLD_WIDTH-1:0] r_hold_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                r_hold_cnt <= '0;
    else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
    else                       r_hold_cnt <= '0;
  end

  assign w_hold_done = (r_hold_cnt == HOLD_LAST);
`else
  assign w_hold_done = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    ACK        = 3'b000;
    BUS_REQ    = 1'b0;
    BUSY       = (r_state != S_IDLE);
    w_drive    = 1'b0;
    w_own_idle = 1'b0;
    case (r_state)
      S_IDLE: if (|REQ) w_next = S_WAIT_GNT;
      S_WAIT_GNT: begin
        BUS_REQ    = 1'b1;
        w_own_idle = BUS_GNT;
        if (BUS_GNT) w_next = S_WR_VAL;
      end
      // Losing the grant mid-sequence releases the bus at once and replays both writes.
      S_WR_VAL, S_WR_DOT: begin
        BUS_REQ = 1'b1;
        w_drive = BUS_GNT;
        if (!BUS_GNT)                w_next = S_WAIT_GNT;
        else if (r_state == S_WR_VAL) w_next = S_WR_DOT;
        else                         w_next = S_DONE;
      end
      S_DONE: begin
        ACK = 3'b001 << r_win;
`ifdef SEG_ARB_HOLD_EN
        w_next = S_HOLD;
`else
        w_next = S_IDLE;
`endif
      end
      default: if (w_hold_done) w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last  <= 2'd2;
      r_win   <= 2'd0;
      r_value <= 8'd0;
      r_dots  <= 4'd0;
    end else begin
      if (r_state == S_IDLE && |REQ) begin
        r_win <= w_pick;
        case (w_pick)
          2'd0:    begin r_value <= VALUE0; r_dots <= DOTS0; end
          2'd1:    begin r_value <= VALUE1; r_dots <= DOTS1; end
          default: begin r_value <= VALUE2; r_dots <= DOTS2; end
        endcase
      end
      if (r_state == S_DONE) r_last <= r_win;
    end
  end

  assign BUS_ADDR = w_drive ? ((r_state == S_WR_DOT) ? SEG_BASE_ADDR + 8'd1 : SEG_BASE_ADDR) : 8'hzz;
  assign BUS_DATA = w_drive ? ((r_state == S_WR_DOT) ? {4'b0000, r_dots} : r_value) : 8'hzz;
  assign BUS_WE   = w_drive ? 1'b1 : (w_own_idle ? 1'b0 : 1'bz);

endmodule
